axi_fill_engine: RTL
====================

// Module: axi_fill_engine
// PURPOSE
//   AXI4 write-only master that fills a memory region with a generated test pattern on command.
//   Software/control logic supplies base, length, mode and seed, then strobes start.
//   The block issues INCR bursts with bounded outstanding writes and reports done/error.
//   Sits between the test-control logic and the memory-under-test (BRAM/HBM).
// PARAMETERS
//   IW              2     AXI ID width
//   AW              20    AXI address width
//   DW              512   AXI data width; multiple of 32, range 32..1024
//   BURST_BYTES     256   bytes per burst; multiple of DW/8; at most 256 beats
//   MAX_OUTSTANDING 8     max AW accepted without matching B response (1..255)
// PORTS
//   clk            in   1        single clock, all logic rising-edge
//   reset          in   1        asynchronous, active-high
//   start          in   1        1-cycle command strobe; sampled only while idle
//   base_addr      in   AW       start byte address; BURST_BYTES-aligned
//   length         in   32       bytes to fill; multiple of BURST_BYTES
//   mode           in   2        pattern select (see BEHAVIOUR)
//   seed           in   32       pattern seed
//   busy           out  1        high from cycle after accepted start until done
//   done           out  1        1-cycle pulse when final B response is received
//   error          out  1        sticky: any BRESP!=OKAY this run; cleared by next start
//   M_AXI_AW*      out  std      AWADDR[AW] AWVALID AWLEN[8] AWSIZE[3] AWID[IW] AWBURST[2] AWLOCK AWCACHE[4] AWQOS[4] AWPROT[3]; AWREADY in
//   M_AXI_W*       out  std      WDATA[DW] WSTRB[DW/8] WVALID WLAST; WREADY in
//   M_AXI_B*       in   std      BRESP[2] BID[IW] BVALID; BREADY out
//   (no read channel; this is a write-only master)
// BEHAVIOUR
//   Reset (async): AWVALID=WVALID=WLAST=0, AWADDR=0, busy=done=error=0, all counters 0, FSM IDLE.
//     Reset mid-run abandons the transfer with no done pulse.
//   Constants: AWLEN=BURST_BYTES/(DW/8)-1, AWSIZE=clog2(DW/8), AWBURST=INCR, WSTRB=all ones.
//     AWID, AWLOCK, AWCACHE, AWQOS and AWPROT are all 0. BREADY=1 at all times.
//   FSM IDLE -> RUN -> DRAIN -> IDLE.
//   Start handling:
//     - IDLE, start=1, length!=0: latch base/length/mode/seed, clear error, go RUN; busy=1 next cycle.
//     - IDLE, start=1, length=0: done pulses on next cycle; no AXI traffic; busy stays 0.
//     - start while busy: ignored.
//   Burst count: N = length/BURST_BYTES.
//   AW channel:
//     - burst k has AWADDR = base + k*BURST_BYTES, mod 2^AW.
//     - AWVALID first rises the cycle after start is accepted.
//     - AWVALID is asserted only while outstanding < MAX_OUTSTANDING,
//       where outstanding = AW accepted - B received.
//     - Once raised, AWVALID and AWADDR hold until AWREADY.
//   Outstanding counter: an AW handshake and a B handshake in the same cycle leave the count unchanged.
//   W channel:
//     - beats of burst k are presented only after AW k has been accepted.
//     - WDATA/WLAST hold while WVALID & !WREADY.
//     - WLAST is asserted on beat AWLEN of each burst; WVALID may stay high across burst boundaries.
//   RUN -> DRAIN when the last W beat is accepted.
//   DRAIN -> IDLE when B count reaches N; done pulses 1 cycle, busy drops in the same cycle.
//   Pattern: 32-bit lane i of global beat b has word index w = b*(DW/32)+i.
//     mode0: seed+w
//     mode1: seed
//     mode2: base+4*w (byte address of that word)
//     mode3: ~(seed+w)
//     All arithmetic is mod 2^32.
//   Error and unexpected responses:
//     - any BRESP!=OKAY sets error; the transfer still completes all N bursts.
//     - BVALID while IDLE is accepted and ignored.
// TESTING
//   1. DW=512, base=0, length=0x1000, mode0, seed=0, slave always ready
//      -> 16 AWs at 0x000..0xF00, AWLEN=3; word n == n for n=0..1023;
//      -> one done pulse after the 16th B; error=0.
//   2. MAX_OUTSTANDING=4, slave withholds BVALID
//      -> exactly 4 AW handshakes, then AWVALID=0 until a B arrives.
//   3. start with length=0 -> done=1 the next cycle; AWVALID and WVALID never assert.
//   4. SLVERR on burst 3 of 8
//      -> all 8 bursts complete; error=1 at done and after;
//      -> the next start clears error.
//   5. Random AWREADY/WREADY stalls, mode2, base=0x4000
//      -> AWADDR/WDATA stable while stalled;
//      -> first words are 0x4000, 0x4004, ...
//   6. reset asserted mid-burst
//      -> outputs 0 immediately (no clock edge needed); no done pulse;
//      -> a new start after release produces the correct full fill.

Source files
------------

// File: rtl/axi_fill_engine_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the fill engine and memory.
interface axi_fill_engine_if #(
  parameter int IW = 2,
  parameter int AW = 20,
  parameter int DW = 512
);
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [3:0]      awqos;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wlast;
  logic            wready;
  logic [1:0]      bresp;
  logic [IW-1:0]   bid;
  logic            bvalid;
  logic            bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awqos, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bresp, bid, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awqos, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bresp, bid, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_fill_engine.sv
// AXI4 write-only fill engine: on a start strobe, writes length bytes from
// base_addr using INCR bursts of BURST_BYTES, with a generated data pattern,
// at most MAX_OUTSTANDING unanswered bursts, and done/error reporting.
module axi_fill_engine #(
  parameter int IW              = 2,
  parameter int AW              = 20,
  parameter int DW              = 512,
  parameter int BURST_BYTES     = 256,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [31:0]       length,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              error,
  axi_fill_engine_if.master m_axi
);

  localparam int         BEAT_BYTES = DW / 8;
  localparam int         BEATS      = BURST_BYTES / BEAT_BYTES;
  localparam int         LANES      = DW / 32;
  localparam logic [7:0] AWLEN_C    = 8'(BEATS - 1);
  localparam logic [2:0] AWSIZE_C   = 3'($clog2(BEAT_BYTES));

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Pattern word for every 32-bit lane of one global beat.
  function automatic logic [DW-1:0] beat_data(input logic [1:0] m, input logic [31:0] s,
                                              input logic [31:0] b, input logic [31:0] beat);
    logic [DW-1:0] d;
    logic [31:0]   w;
    d = {DW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w = beat * 32'(LANES) + 32'(i);
      case (m)
        2'd0:    d[i*32 +: 32] = s + w;
        2'd1:    d[i*32 +: 32] = s;
        2'd2:    d[i*32 +: 32] = b + (w << 2);
        default: d[i*32 +: 32] = ~(s + w);
      endcase
    end
    return d;
  endfunction

  logic [1:0]    state_r;
  logic          busy_r, done_r, error_r;
  logic [AW-1:0] base_r;
  logic [1:0]    mode_r;
  logic [31:0]   seed_r, nburst_r;
  logic [31:0]   aw_cnt_r, b_cnt_r, w_burst_r, beat_idx_r;
  logic [7:0]    w_in_r;
  logic [8:0]    outstanding_r;
  logic          awvalid_r, wvalid_r, wlast_r;
  logic [AW-1:0] awaddr_r;
  logic [DW-1:0] wdata_r;

  logic          aw_hs_s, w_hs_s, b_hs_s, b_dec_s, b_err_s, active_s, accept_s, run_start_s;
  logic          last_beat_s, final_w_s, aw_want_s, w_want_s;
  logic [31:0]   nburst_s, aw_cnt_nx_s, b_cnt_nx_s, w_burst_nx_s, beat_nx_s;
  logic [7:0]    w_in_nx_s;
  logic [8:0]    out_nx_s;
  logic          unused_s;

  // Handshakes and next values of all transfer counters.
  always_comb begin
    aw_hs_s     = awvalid_r & m_axi.awready;
    w_hs_s      = wvalid_r & m_axi.wready;
    b_hs_s      = m_axi.bvalid;
    active_s    = (state_r != ST_IDLE);
    accept_s    = (state_r == ST_IDLE) & start;
    nburst_s    = length / 32'(BURST_BYTES);
    run_start_s = accept_s & (nburst_s != 32'd0);
    b_dec_s     = b_hs_s & active_s & ((outstanding_r != 9'd0) | aw_hs_s);
    b_err_s     = b_hs_s & active_s & (m_axi.bresp != 2'b00);
    last_beat_s = (w_in_r == AWLEN_C);
    final_w_s   = w_hs_s & last_beat_s & (w_burst_r == nburst_r - 32'd1);
    aw_cnt_nx_s = aw_cnt_r + {31'd0, aw_hs_s};
    b_cnt_nx_s  = b_cnt_r + {31'd0, b_hs_s & active_s};
    beat_nx_s   = beat_idx_r + {31'd0, w_hs_s};
    if (w_hs_s && last_beat_s) begin
      w_in_nx_s    = 8'd0;
      w_burst_nx_s = w_burst_r + 32'd1;
    end else if (w_hs_s) begin
      w_in_nx_s    = w_in_r + 8'd1;
      w_burst_nx_s = w_burst_r;
    end else begin
      w_in_nx_s    = w_in_r;
      w_burst_nx_s = w_burst_r;
    end
    if (aw_hs_s && !b_dec_s) begin
      out_nx_s = outstanding_r + 9'd1;
    end else if (!aw_hs_s && b_dec_s) begin
      out_nx_s = outstanding_r - 9'd1;
    end else begin
      out_nx_s = outstanding_r;
    end
    aw_want_s = (state_r == ST_RUN) && (aw_cnt_nx_s < nburst_r) &&
                (out_nx_s < 9'(MAX_OUTSTANDING));
    w_want_s  = (state_r == ST_RUN) && (w_burst_nx_s < aw_cnt_nx_s);
  end

  // Control FSM with busy/done/error status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            error_r <= 1'b0;
            if (nburst_s != 32'd0) begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (b_err_s) error_r <= 1'b1;
          if (final_w_s) state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (b_err_s) error_r <= 1'b1;
          if (b_cnt_nx_s == nburst_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Command latches and per-run counters (AW issued, B received, W position).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_r        <= {AW{1'b0}};
      mode_r        <= 2'd0;
      seed_r        <= 32'd0;
      nburst_r      <= 32'd0;
      aw_cnt_r      <= 32'd0;
      b_cnt_r       <= 32'd0;
      w_burst_r     <= 32'd0;
      beat_idx_r    <= 32'd0;
      w_in_r        <= 8'd0;
      outstanding_r <= 9'd0;
    end else if (run_start_s) begin
      base_r        <= base_addr;
      mode_r        <= mode;
      seed_r        <= seed;
      nburst_r      <= nburst_s;
      aw_cnt_r      <= 32'd0;
      b_cnt_r       <= 32'd0;
      w_burst_r     <= 32'd0;
      beat_idx_r    <= 32'd0;
      w_in_r        <= 8'd0;
      outstanding_r <= 9'd0;
    end else if (active_s) begin
      aw_cnt_r      <= aw_cnt_nx_s;
      b_cnt_r       <= b_cnt_nx_s;
      w_burst_r     <= w_burst_nx_s;
      beat_idx_r    <= beat_nx_s;
      w_in_r        <= w_in_nx_s;
      outstanding_r <= out_nx_s;
    end else begin
      outstanding_r <= outstanding_r;
    end
  end

  // AW channel: raise on start, hold while stalled, otherwise gate on the outstanding limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awvalid_r <= 1'b0;
      awaddr_r  <= {AW{1'b0}};
    end else if (run_start_s) begin
      awvalid_r <= 1'b1;
      awaddr_r  <= base_addr;
    end else if (awvalid_r && !m_axi.awready) begin
      awvalid_r <= 1'b1;
    end else begin
      awvalid_r <= aw_want_s;
      if (aw_hs_s) awaddr_r <= awaddr_r + AW'(BURST_BYTES);
    end
  end

  // W channel: present the next beat only once its burst address has been accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wvalid_r <= 1'b0;
      wlast_r  <= 1'b0;
      wdata_r  <= {DW{1'b0}};
    end else if (accept_s) begin
      wvalid_r <= 1'b0;
      wlast_r  <= 1'b0;
    end else if (wvalid_r && !m_axi.wready) begin
      wvalid_r <= 1'b1;
    end else begin
      wvalid_r <= w_want_s;
      wlast_r  <= (w_in_nx_s == AWLEN_C);
      wdata_r  <= beat_data(mode_r, seed_r, 32'(base_r), beat_nx_s);
    end
  end

  assign unused_s = ^m_axi.bid;

  assign busy  = busy_r;
  assign done  = done_r;
  assign error = error_r;

  assign m_axi.awid    = {IW{1'b0}};
  assign m_axi.awaddr  = awaddr_r;
  assign m_axi.awlen   = AWLEN_C;
  assign m_axi.awsize  = AWSIZE_C;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awvalid = awvalid_r;
  assign m_axi.wdata   = wdata_r;
  assign m_axi.wstrb   = {(DW/8){1'b1}};
  assign m_axi.wvalid  = wvalid_r;
  assign m_axi.wlast   = wlast_r;
  assign m_axi.bready  = 1'b1;

endmodule
